// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
//   Shared definitions for the perceptron datapath: default geometry, the
//   fixed-point ONE constant, and the PLAN sigmoid breakpoints and offsets.
//
//   The constants are produced by fx_const() so that a block instantiated with
//   a non-default FRAC can derive its own copies with exactly the same
//   formula. The packaged values below are the Q8.24 defaults.
//
//   Ports: none (package).
// -----------------------------------------------------------------------------
package perceptron_pkg;

    localparam int DEF_NUM   = 2;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 24;

    // mant / 2^sh expressed with frac fractional bits, i.e. mant << (frac - sh).
    // Every PLAN constant is a short dyadic fraction, so this is exact.
    function automatic longint fx_const(input longint mant, input int sh, input int frac);
        return mant <<< (frac - sh);
    endfunction

    // Fixed-point one.
    localparam longint ONE          = fx_const(1, 0, DEF_FRAC);

    // PLAN breakpoints on x = |z|.
    localparam longint BP_1_0       = fx_const(1, 0, DEF_FRAC);   // 1.0
    localparam longint BP_2_375     = fx_const(19, 3, DEF_FRAC);  // 2.375 = 19/8
    localparam longint BP_5_0       = fx_const(5, 0, DEF_FRAC);   // 5.0

    // PLAN segment offsets.
    localparam longint OFF_0_5      = fx_const(1, 1, DEF_FRAC);   // 0.5
    localparam longint OFF_0_625    = fx_const(5, 3, DEF_FRAC);   // 0.625 = 5/8
    localparam longint OFF_0_84375  = fx_const(27, 5, DEF_FRAC);  // 0.84375 = 27/32

    // PLAN slopes as right-shift amounts: 1/4, 1/8, 1/32.
    localparam int SH_SEG0 = 2;
    localparam int SH_SEG1 = 3;
    localparam int SH_SEG2 = 5;

endpackage

// File: rtl/perceptron_if.sv
// -----------------------------------------------------------------------------
// perceptron_if
//   Sample/result bundle for the perceptron.
//
//   Handshake: valid-only, no ready. The master presents i_k/i_w/i_b with
//   i_valid=1 for exactly the cycle the sample should be taken; the slave
//   always accepts. o_valid=1 marks the single cycle in which o carries a new
//   result; o keeps its last value while o_valid=0. There is no backpressure.
//
//   Signals:
//     i_valid  sample valid this cycle
//     i_k      NUM packed signed inputs, element n at [n*WIDTH +: WIDTH]
//     i_w      NUM packed signed weights, same packing
//     i_b      signed bias
//     o        sigmoid activation, same fixed-point format
//     o_valid  o holds a fresh result
//   Modports: master (sample source / result sink), slave (perceptron).
// -----------------------------------------------------------------------------
interface perceptron_if
    import perceptron_pkg::*;
#(
    parameter int NUM   = DEF_NUM,
    parameter int WIDTH = DEF_WIDTH
);

    logic                 i_valid;
    logic [NUM*WIDTH-1:0] i_k;
    logic [NUM*WIDTH-1:0] i_w;
    logic [WIDTH-1:0]     i_b;
    logic [WIDTH-1:0]     o;
    logic                 o_valid;

    modport master (
        output i_valid,
        output i_k,
        output i_w,
        output i_b,
        input  o,
        input  o_valid
    );

    modport slave (
        input  i_valid,
        input  i_k,
        input  i_w,
        input  i_b,
        output o,
        output o_valid
    );

endinterface

// File: rtl/perceptron_sigmoid_plan.sv
// -----------------------------------------------------------------------------
// sigmoid_plan
//   Purely combinational PLAN approximation of the logistic sigmoid.
//     y(x) for x = |z|:
//       x >= 5.0           -> 1.0
//       2.375 <= x < 5.0   -> x/32 + 0.84375
//       1.0   <= x < 2.375 -> x/8  + 0.625
//       x < 1.0            -> x/4  + 0.5
//     a = y(|z|) for z >= 0, a = 1.0 - y(|z|) for z < 0.
//   Slopes are arithmetic shifts. Breakpoints belong to the upper segment.
//
//   Ports:
//     z  in   WIDTH  signed pre-activation, Q(WIDTH-FRAC).FRAC
//     a  out  WIDTH  activation in [0, 1.0], same format
// -----------------------------------------------------------------------------
module sigmoid_plan
    import perceptron_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic signed [WIDTH-1:0] z,
    output logic        [WIDTH-1:0] a
);

    localparam logic signed [WIDTH-1:0] ONE_L   = WIDTH'(fx_const(1, 0, FRAC));
    localparam logic signed [WIDTH-1:0] BP1_L   = WIDTH'(fx_const(1, 0, FRAC));
    localparam logic signed [WIDTH-1:0] BP2_L   = WIDTH'(fx_const(19, 3, FRAC));
    localparam logic signed [WIDTH-1:0] BP3_L   = WIDTH'(fx_const(5, 0, FRAC));
    localparam logic signed [WIDTH-1:0] OFF0_L  = WIDTH'(fx_const(1, 1, FRAC));
    localparam logic signed [WIDTH-1:0] OFF1_L  = WIDTH'(fx_const(5, 3, FRAC));
    localparam logic signed [WIDTH-1:0] OFF2_L  = WIDTH'(fx_const(27, 5, FRAC));
    localparam logic signed [WIDTH-1:0] MIN_L   = {1'b1, {(WIDTH-1){1'b0}}};

    logic                    z_neg;
    logic                    z_min;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;

    always_comb begin
        z_neg = z[WIDTH-1];
        // |most-negative| does not fit in WIDTH bits; it is far beyond the
        // saturation breakpoint, so it is forced to a = 0 below.
        z_min = (z == MIN_L);
        x     = z_neg ? -z : z;

        if (x >= BP3_L) begin
            y = ONE_L;
        end else if (x >= BP2_L) begin
            y = (x >>> SH_SEG2) + OFF2_L;
        end else if (x >= BP1_L) begin
            y = (x >>> SH_SEG1) + OFF1_L;
        end else begin
            y = (x >>> SH_SEG0) + OFF0_L;
        end

        if (z_min) begin
            a = '0;
        end else if (z_neg) begin
            a = ONE_L - y;
        end else begin
            a = y;
        end
    end

endmodule

// File: rtl/perceptron.sv
// -----------------------------------------------------------------------------
// perceptron
//   Single neuron: a = sigmoid(sum_n k[n]*w[n] + b) in signed fixed point.
//
//   Pipeline (one sample per cycle, latency 3):
//     stage 1  saturated, rescaled products k[n]*w[n] and the bias
//     stage 2  saturated sum z
//     stage 3  activation o (only loaded when the sample is valid)
//   i_valid travels alongside the data and becomes o_valid. The datapath
//   advances every cycle; only the output register is qualified by valid so
//   that o holds between results.
//
//   Ports:
//     i_clk    in   1  rising-edge clock
//     i_rst_n  in   1  asynchronous active-low reset, clears the whole pipe
//     bus      slave perceptron_if (i_valid, i_k, i_w, i_b, o, o_valid)
// -----------------------------------------------------------------------------
module perceptron
    import perceptron_pkg::*;
#(
    parameter int NUM   = DEF_NUM,
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    perceptron_if.slave   bus
);

    localparam int PROD_W = 2 * WIDTH;
    // Enough headroom to add NUM saturated products plus the bias exactly.
    localparam int GUARD  = $clog2(NUM + 1);
    localparam int ACC_W  = WIDTH + GUARD;

    localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1
    logic signed [WIDTH-1:0] prod_sat [NUM];
    logic signed [WIDTH-1:0] prod_q   [NUM];
    logic signed [WIDTH-1:0] b1_q;
    logic                    v1_q;

    // Stage 2
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] z_sat;
    logic signed [WIDTH-1:0] z2_q;
    logic                    v2_q;

    // Stage 3
    logic        [WIDTH-1:0] a_c;
    logic        [WIDTH-1:0] o_q;
    logic                    o_valid_q;

    // Multipliers: full-precision product, floor rescale by FRAC, then clamp
    // to WIDTH. The clamp is needed whenever the rescaled value's bits above
    // the WIDTH-1 sign position are not all copies of the sign.
    for (genvar n = 0; n < NUM; n++) begin : g_mult
        logic signed [WIDTH-1:0]  k_n;
        logic signed [WIDTH-1:0]  w_n;
        logic signed [PROD_W-1:0] full;
        logic signed [PROD_W-1:0] shr;

        assign k_n  = bus.i_k[n*WIDTH +: WIDTH];
        assign w_n  = bus.i_w[n*WIDTH +: WIDTH];
        assign full = PROD_W'(k_n) * PROD_W'(w_n);
        assign shr  = full >>> FRAC;

        assign prod_sat[n] =
            (&shr[PROD_W-1:WIDTH-1] || ~|shr[PROD_W-1:WIDTH-1]) ? shr[WIDTH-1:0] :
            (shr[PROD_W-1] ? MIN_W : MAX_W);
    end

    // Accumulate the registered products with guard bits, then clamp to z.
    always_comb begin
        acc = ACC_W'(b1_q);
        for (int n = 0; n < NUM; n++) begin
            acc = acc + ACC_W'(prod_q[n]);
        end

        if (&acc[ACC_W-1:WIDTH-1] || ~|acc[ACC_W-1:WIDTH-1]) begin
            z_sat = acc[WIDTH-1:0];
        end else begin
            z_sat = acc[ACC_W-1] ? MIN_W : MAX_W;
        end
    end

    sigmoid_plan #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_act (
        .z (z2_q),
        .a (a_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < NUM; n++) begin
                prod_q[n] <= '0;
            end
            b1_q      <= '0;
            v1_q      <= 1'b0;
            z2_q      <= '0;
            v2_q      <= 1'b0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            for (int n = 0; n < NUM; n++) begin
                prod_q[n] <= prod_sat[n];
            end
            b1_q      <= bus.i_b;
            v1_q      <= bus.i_valid;
            z2_q      <= z_sat;
            v2_q      <= v1_q;
            o_valid_q <= v2_q;
            if (v2_q) begin
                o_q <= a_c;
            end
        end
    end

    assign bus.o       = o_q;
    assign bus.o_valid = o_valid_q;

endmodule

// File: tb/tb_perceptron.sv
// -----------------------------------------------------------------------------
// tb_perceptron
//   Directed and randomized checks of the perceptron at NUM=2, Q8.24.
//   Expected outputs come from spec constants for directed vectors and from a
//   longint arithmetic reference model for random ones.
// -----------------------------------------------------------------------------
module tb_perceptron;

    localparam int NUM   = 2;
    localparam int WIDTH = 32;

    localparam longint MAXV  = 2147483647;
    localparam longint MINV  = -MAXV - 1;
    localparam longint ONE_R = 16777216;   // 1.0 in Q8.24

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perceptron_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();

    perceptron #(
        .NUM   (NUM),
        .WIDTH (WIDTH),
        .FRAC  (24)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic             exp_v_q[$];
    logic [WIDTH-1:0] exp_q[$];
    string            tag_q[$];
    logic [WIDTH-1:0] hold_o = '0;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sat32(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] ref_model(input logic [31:0] k0, input logic [31:0] k1,
                                                   input logic [31:0] w0, input logic [31:0] w1,
                                                   input logic [31:0] b);
        longint kk[2];
        longint ww[2];
        longint z, x, y, a;
        kk[0] = longint'($signed(k0));
        kk[1] = longint'($signed(k1));
        ww[0] = longint'($signed(w0));
        ww[1] = longint'($signed(w1));
        z = longint'($signed(b));
        for (int i = 0; i < 2; i++) begin
            z = z + sat32((kk[i] * ww[i]) >>> 24);
        end
        z = sat32(z);
        x = (z < 0) ? -z : z;
        if (x >= 5 * ONE_R)                  y = ONE_R;
        else if (x >= (19 * ONE_R) / 8)      y = x / 32 + (27 * ONE_R) / 32;
        else if (x >= ONE_R)                 y = x / 8 + (5 * ONE_R) / 8;
        else                                 y = x / 4 + ONE_R / 2;
        a = (z < 0) ? ONE_R - y : y;
        return a[WIDTH-1:0];
    endfunction

    // ---------------- driver ----------------
    // Present one input cycle, advance a clock, then check the output that
    // the sample presented two cycles earlier should now have produced.
    task automatic step(input logic v, input logic [31:0] k0, input logic [31:0] k1,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] b,
                        input logic [WIDTH-1:0] exp, input string tag);
        logic             ev;
        logic [WIDTH-1:0] ea;
        string            et;
        bus.i_valid = v;
        bus.i_k     = {k1, k0};
        bus.i_w     = {w1, w0};
        bus.i_b     = b;
        exp_v_q.push_back(v);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        ev = 1'b0;
        et = "pipe_fill";
        if (exp_v_q.size() == 3) begin
            ev = exp_v_q.pop_front();
            ea = exp_q.pop_front();
            et = tag_q.pop_front();
            if (ev) hold_o = ea;
        end
        check({et, "_valid"}, {31'b0, bus.o_valid}, {31'b0, ev});
        check({et, "_o"}, bus.o, hold_o);
    endtask

    task automatic sample_const(input logic [31:0] k0, input logic [31:0] k1,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] b, input logic [WIDTH-1:0] exp,
                                input string tag);
        step(1'b1, k0, k1, w0, w1, b, exp, tag);
    endtask

    task automatic sample_rand();
        int          ib0, ib1;
        logic [31:0] k0, k1, w0, w1, b;
        ib0 = int'($urandom_range(0, 4)) - 2;
        ib1 = int'($urandom_range(0, 4)) - 2;
        k0  = {ib0[7:0], 24'($urandom)};
        k1  = {ib1[7:0], 24'($urandom)};
        w0  = {8'h00, 24'($urandom)};
        w1  = {8'h00, 24'($urandom)};
        b   = {8'h00, 24'($urandom)};
        step(1'b1, k0, k1, w0, w1, b, ref_model(k0, k1, w0, w1, b), "random");
    endtask

    task automatic idle();
        step(1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, '0, "idle");
    endtask

    task automatic flush();
        repeat (3) idle();
    endtask

    // Assert reset away from the clock edge; outputs must clear at once.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_o"}, bus.o, '0);
        check({tag, "_rst_valid"}, {31'b0, bus.o_valid}, 32'd0);
        exp_v_q.delete();
        exp_q.delete();
        tag_q.delete();
        hold_o = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.i_valid = 1'b0;
        bus.i_k     = '0;
        bus.i_w     = '0;
        bus.i_b     = '0;

        #12;
        check("por_o", bus.o, '0);
        check("por_valid", {31'b0, bus.o_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, issued back to back on consecutive cycles.
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00800000, "zero");
        sample_const(32'h01000000, 32'h0, 32'h01000000, 32'h0, 32'h0, 32'h00C00000, "z_plus1");
        sample_const(32'h01000000, 32'h0, 32'hFF000000, 32'h0, 32'h0, 32'h00400000, "z_minus1");
        sample_const(32'h00800000, 32'h0, 32'h01000000, 32'h0, 32'h0, 32'h00A00000, "z_half");
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'h06000000, 32'h01000000, "z_six");
        sample_const(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h0, 32'h01000000, "sat_pos");
        sample_const(32'h7F000000, 32'h7F000000, 32'h81000000, 32'h81000000, 32'h0, 32'h00000000, "sat_neg");
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000, 32'h00000000, "z_min");
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'h00FFFFFF, 32'h00BFFFFF, "below_1p0");
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'h025FFFFF, 32'h00EBFFFF, "below_2p375");
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'h02600000, 32'h00EB0000, "at_2p375");
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'hFDA00000, 32'h00150000, "at_neg2p375");
        sample_const(32'h0, 32'h0, 32'h0, 32'h0, 32'h05000000, 32'h01000000, "at_5p0");
        sample_const(32'hFFFFFFF9, 32'h0, 32'h00800000, 32'h0, 32'h0, 32'h007FFFFF, "floor_trunc");
        sample_const(32'h7F000000, 32'h0, 32'h7F000000, 32'h0, 32'h7FFFFFFF, 32'h01000000, "guard_pos");
        flush();

        // Reset in the middle of a stream: no stale o_valid afterwards.
        sample_rand();
        sample_rand();
        sample_rand();
        apply_reset("midstream");
        idle();
        idle();
        idle();
        sample_const(32'h01000000, 32'h0, 32'h01000000, 32'h0, 32'h0, 32'h00C00000, "post_reset");
        flush();

        // Randomized samples with occasional idle gaps.
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            sample_rand();
        end
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
